// File: rtl/div32_seq_if.sv
// Handshake and result bundle for the sequential 32-bit divider.
// master = requester (control unit / bench), slave = div32_seq.
interface div32_seq_if;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider, one trial subtraction per cycle.
// Optional signed (truncating) division is enabled by defining DIV_SIGNED_EN.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on the accepting edge
// RUN    | 32 shift/trial-subtract iterations
// ZERO   | one-cycle divide-by-zero completion
module div32_seq (
   input logic        clk_i,
   input logic        rst_i,
   div32_seq_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO} state_t;

   state_t      state_q, state_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rmd_q, rmd_d;
   logic        done_q, done_d;
   logic        dbz_q, dbz_d;
   logic        busy_q;

   logic [32:0] rem_shift;
   logic [32:0] diff;
   logic        qbit;
   logic [31:0] quo_raw;
   logic [31:0] rem_next;
   logic        div_zero;

   assign div_zero = (bus.divisor == 32'd0);

`ifdef DIV_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;
   logic sgn_a, sgn_b;
   assign sgn_a = bus.signed_op & bus.dividend[31];
   assign sgn_b = bus.signed_op & bus.divisor[31];
`else
   logic signed_op_unused;
   assign signed_op_unused = bus.signed_op;
`endif

   always_ff @(posedge clk_i) begin : p_state
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin : p_next
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = div_zero ? S_ZERO : S_RUN;
         S_RUN:   if (cnt_q == 6'd31) state_d = S_IDLE;
         S_ZERO:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Dividend register doubles as the quotient shift register.
   assign rem_shift = {rem_q, dvd_q[31]};
   assign diff      = rem_shift - {1'b0, dvs_q};
   assign qbit      = ~diff[32];
   assign quo_raw   = {dvd_q[30:0], qbit};
   assign rem_next  = qbit ? diff[31:0] : rem_shift[31:0];

   always_comb begin : p_out
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      quo_d  = quo_q;
      rmd_d  = rmd_q;
      dbz_d  = dbz_q;
      done_d = 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               rem_d = 32'd0;
               cnt_d = 6'd0;
`ifdef DIV_SIGNED_EN
               neg_quo_d = sgn_a ^ sgn_b;
               neg_rem_d = sgn_a;
               dvs_d     = sgn_b ? (32'd0 - bus.divisor) : bus.divisor;
               // Divide-by-zero returns the dividend untouched, so keep its raw form.
               dvd_d     = (sgn_a && !div_zero) ? (32'd0 - bus.dividend) : bus.dividend;
`else
               dvs_d = bus.divisor;
               dvd_d = bus.dividend;
`endif
            end
         end
         S_RUN: begin
            rem_d = rem_next;
            dvd_d = quo_raw;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
`ifdef DIV_SIGNED_EN
               quo_d = neg_quo_q ? (32'd0 - quo_raw)  : quo_raw;
               rmd_d = neg_rem_q ? (32'd0 - rem_next) : rem_next;
`else
               quo_d = quo_raw;
               rmd_d = rem_next;
`endif
               dbz_d  = 1'b0;
               done_d = 1'b1;
            end
         end
         S_ZERO: begin
            quo_d  = 32'hFFFF_FFFF;
            rmd_d  = dvd_q;
            dbz_d  = 1'b1;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin : p_regs
      if (rst_i) begin
         dvd_q  <= 32'd0;
         dvs_q  <= 32'd0;
         rem_q  <= 32'd0;
         cnt_q  <= 6'd0;
         quo_q  <= 32'd0;
         rmd_q  <= 32'd0;
         dbz_q  <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rmd_q  <= rmd_d;
         dbz_q  <= dbz_d;
         done_q <= done_d;
         busy_q <= (state_d != S_IDLE);
`ifdef DIV_SIGNED_EN
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rmd_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_div32_seq;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   div32_seq_if bus ();

   div32_seq dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, got no end, required end");
      $fatal(1, "timeout");
   end

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got done=1 with q=%h r=%h, required no pending operation",
                     bus.quotient, bus.remainder);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
               n_fail++;
               $display("FAIL result: got q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                        bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
            end
         end
      end
   end

   task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, got, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", nm, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input logic ed,
                        input bit push);
      exp_t e;
      e.q = eq; e.r = er; e.dbz = ed;
      if (push) sb.push_back(e);
      bus.start     = 1'b1;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.signed_op = s;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   // k0 = rising edges already elapsed since the accepting edge.
   task automatic wait_done(input int k0, input int elat, input string nm);
      int k;
      k = k0;
      chk1({nm, "_busy_high"}, bus.busy, 1'b1);
      while (bus.done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (bus.done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: got no done within %0d cycles, required done after %0d", nm, k, elat);
      end else begin
         if (k != elat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", nm, k, elat);
         end
         chk1({nm, "_busy_low_at_done"}, bus.busy, 1'b0);
      end
   endtask

   initial begin
      int dn;
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = 32'd0;
      bus.divisor   = 32'd0;
      repeat (3) @(negedge clk);
      chk1 ("rst_busy", bus.busy, 1'b0);
      chk1 ("rst_done", bus.done, 1'b0);
      chk32("rst_quotient", bus.quotient, 32'd0);
      chk32("rst_remainder", bus.remainder, 32'd0);
      chk1 ("rst_dbz", bus.div_by_zero, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);
      wait_done(0, 32, "div_100_7");
      @(negedge clk);

      issue(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b1);
      wait_done(0, 1, "div_zero");
      @(negedge clk);

      // start mid-operation with new operands must be ignored
      issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);
      repeat (9) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd5;
      @(negedge clk);
      bus.start    = 1'b0;
      wait_done(10, 32, "ignored_start");

      // back-to-back: start in the done cycle
      issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b1);
      wait_done(0, 32, "back_to_back");
      @(negedge clk);

      // reset at E15 aborts; no done afterwards
      issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk1 ("abort_busy", bus.busy, 1'b0);
      chk1 ("abort_done", bus.done, 1'b0);
      chk32("abort_quotient", bus.quotient, 32'd0);
      chk32("abort_remainder", bus.remainder, 32'd0);
      rst = 1'b0;
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) dn++;
      end
      n_tests++;
      if (dn != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d done pulses, required 0", dn);
      end

`ifdef DIV_SIGNED_EN
      issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
`else
      issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b1);
`endif
      wait_done(0, 32, "neg7_by_2");
      @(negedge clk);

      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
      wait_done(0, 32, "max_by_1");
      @(negedge clk);

      issue(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 1'b1);
      wait_done(0, 32, "small_by_large");
      repeat (3) @(negedge clk);
      chk32("hold_quotient", bus.quotient, 32'd0);
      chk32("hold_remainder", bus.remainder, 32'd5);

`ifdef DIV_SIGNED_EN
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
`else
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
`endif
      wait_done(0, 32, "overflow");
      @(negedge clk);

      issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b1);
      wait_done(0, 1, "signed_zero");

      repeat (3) @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div32_seq.md
# div32_seq

Sequential 32-bit restoring divider for the KGPminiRISC datapath: the subtraction-based inverse of the lookahead adder chain. It accepts a dividend/divisor pair on a start pulse and performs one trial subtraction per cycle. After 32 iterations it returns the quotient and remainder with a one-cycle done pulse. It sits beside the ALU and serves multi-cycle DIV/REM-style operations, with the control unit stalling on `busy`.

## Interface
- No parameters; width fixed at 32.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request. Sampled only in IDLE.
- `signed_op` input 1: treat operands as two's complement. Effective only with `DIV_SIGNED_EN`.
- `dividend` input 32: numerator, sampled on the accepting edge.
- `divisor` input 32: denominator, sampled on the accepting edge.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle pulse when results are valid.
- `quotient` output 32: result quotient, held until the next completion.
- `remainder` output 32: result remainder, held until the next completion.
- `div_by_zero` output 1: flag for the last completed operation. Updated together with `done`.

## Operation
- States: IDLE, RUN, ZERO.
- IDLE: on edge with `start`=1, register the operands and clear the 33-bit partial remainder and the 6-bit count.
  - If divisor==0, go to ZERO.
  - Otherwise go to RUN.
- RUN, each edge:
  - Shift the partial remainder left and insert the next dividend MSB.
  - Trial-subtract the divisor using a 33-bit subtract.
  - If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Increment count. On the 32nd iteration: write `quotient`/`remainder`, set `done`=1, clear `div_by_zero`, go to IDLE.
- ZERO, one edge:
  - `quotient`=32'hFFFF_FFFF, `remainder`=dividend.
  - `div_by_zero`=1, `done`=1, go to IDLE.
- `start` while not IDLE is ignored. Operands are not re-sampled.
- `done` is cleared on every edge where it is not being set.
- Reset mid-operation aborts the operation. All state and outputs return to reset values and the partial result is discarded.
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.

## Timing
- `busy` = (state != IDLE), registered.
  - Rises the cycle after the accepting edge E0.
  - Falls in the same cycle `done` rises.
- Normal divide: iterations occur on edges E1..E32. `done` and results are visible after E32, which is 32 cycles after E0.
- Divide by zero: `done` is visible after E1.
- Back-to-back: `start` asserted during the `done` cycle is accepted, because state is already IDLE. Throughput is one divide per 33 cycles.
- `quotient`/`remainder`/`div_by_zero` are stable from the `done` cycle until the next `done`.

## Configuration
- Macro: `DIV_SIGNED_EN`.
- Defined, when `signed_op`=1:
  - At E0, latch the operand signs and replace the operands with their magnitudes.
  - At completion, negate the quotient if the signs differ. The remainder takes the dividend's sign (truncating division).
  - Overflow case 32'h8000_0000 / 32'hFFFF_FFFF gives quotient 32'h8000_0000, remainder 0, with no flag.
  - Divide by zero still returns all-ones and the original (signed) dividend.
- Not defined: `signed_op` is ignored and all operations are unsigned. No sign logic is synthesized.

## Test plan
- Unsigned divide: dividend=100, divisor=7, `start` 1 cycle -> `busy` for 32 cycles. `done` after E32 with quotient=14, remainder=2, div_by_zero=0.
- Divide by zero: dividend=0x1234, divisor=0 -> `done` after E1. quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- `DIV_SIGNED_EN` defined, signed_op=1, dividend=0xFFFFFFF9 (-7), divisor=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - Same stimulus with the macro undefined -> quotient=0x7FFFFFFC, remainder=1.
- `start` pulsed at E10 with new operands 50/5 -> ignored; the original 100/7 result is returned unchanged. Then `start` during the `done` cycle with 50/5 -> accepted, and `done` 32 cycles later with quotient=10, remainder=0.
- `rst` high at E15 of an operation -> next cycle busy=0, done=0, quotient=0, remainder=0. No `done` pulse follows.
- Boundary operands:
  - 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
